// File: rtl/button_event_arbiter.sv
// Classifies debounced button presses as short/long and queues the resulting
// events round-robin into a show-ahead FIFO with a valid/ready consumer port.
module button_event_arbiter #(
  parameter int unsigned N_BTN       = 4,
  parameter int unsigned LONG_CYCLES = 100,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_in,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_btn,
  output logic                     evt_long,
  output logic                     overflow,
  output logic                     busy
);

  localparam int unsigned BTN_W = $clog2(N_BTN);
  localparam int unsigned CNT_W = $clog2(LONG_CYCLES);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  // cnt counts high samples after the first, so LONG_CYCLES highs end at this value
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_e;

  btn_state_e       state_q [N_BTN];
  btn_state_e       state_d [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];
  logic [N_BTN-1:0] req, req_long;
  logic [N_BTN-1:0] pend_v_q, pend_v_d, pend_l_q, pend_l_d;
  logic [BTN_W-1:0] rr_q, rr_d, win;
  logic [31:0]      idx;
  logic             found, push, pop, full;
  logic             overflow_q, overflow_d;

  logic [BTN_W-1:0]      mem_btn_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_long_q;
  logic [PTR_W-1:0]      wr_q, rd_q;
  logic [PTR_W:0]        count_q;

  // Per-button press classifier
  always_comb begin
    for (int unsigned i = 0; i < N_BTN; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      req[i]      = 1'b0;
      req_long[i] = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (btn_in[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end
        end
        PRESSED: begin
          if (!btn_in[i]) begin
            state_d[i] = IDLE;
            req[i]     = 1'b1;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]  = HELD;
            req[i]      = 1'b1;
            req_long[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        HELD: begin
          if (!btn_in[i]) state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  assign full = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign pop  = evt_valid & evt_ready;

  // Round-robin pick among pending slots, starting at rr_q
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      idx = (32'(rr_q) + i) % N_BTN;
      if (!found && pend_v_q[idx[BTN_W-1:0]]) begin
        found = 1'b1;
        win   = idx[BTN_W-1:0];
      end
    end
    push = found & (~full | pop);
    rr_d = rr_q;
    if (push) rr_d = (32'(win) == N_BTN - 1) ? '0 : win + BTN_W'(1);
  end

  // Pending slots: a slot freed by this cycle's push may take a new request
  always_comb begin
    pend_v_d   = pend_v_q;
    pend_l_d   = pend_l_q;
    overflow_d = overflow_q;
    if (push) pend_v_d[win] = 1'b0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (req[i]) begin
        if (pend_v_d[i]) begin
          overflow_d = 1'b1;
        end else begin
          pend_v_d[i] = 1'b1;
          pend_l_d[i] = req_long[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_btn_q[i] <= '0;
      mem_long_q <= '0;
      pend_v_q   <= '0;
      pend_l_q   <= '0;
      rr_q       <= '0;
      overflow_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pend_v_q   <= pend_v_d;
      pend_l_q   <= pend_l_d;
      rr_q       <= rr_d;
      overflow_q <= overflow_d;
      if (push) begin
        mem_btn_q[wr_q]  <= win;
        mem_long_q[wr_q] <= pend_l_q[win];
        wr_q             <= wr_q + PTR_W'(1);
      end
      if (pop) rd_q <= rd_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign evt_valid = (count_q != '0);
  assign evt_btn   = mem_btn_q[rd_q];
  assign evt_long  = mem_long_q[rd_q];
  assign overflow  = overflow_q;

  always_comb begin
    busy = (count_q != '0) | (|pend_v_q);
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (state_q[i] != IDLE) busy = 1'b1;
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural model (hold-length counting, pending slots, queue FIFO).
module tb_button_event_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned LC = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned BW = 2;

  typedef struct packed {
    logic [BW-1:0] btn;
    logic          lng;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  btn_in;
  logic          evt_valid, evt_ready, evt_long, overflow, busy;
  logic [BW-1:0] evt_btn;

  button_event_arbiter #(.N_BTN(N), .LONG_CYCLES(LC), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_btn(evt_btn), .evt_long(evt_long),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  ev_t mq[$];
  ev_t obs[$];
  int  hc[N];
  bit  pv[N];
  bit  pl[N];
  int  rr;
  bit  movf;
  int  n_cmp = 0;
  int  n_err = 0;

  function automatic logic [BW+1:0] exp_out();
    return (mq.size() != 0) ? {1'b1, mq[0]} : '0;
  endfunction

  function automatic logic [BW+1:0] dut_out();
    return evt_valid ? {1'b1, evt_btn, evt_long} : '0;
  endfunction

  function automatic bit exp_busy();
    bit b = (mq.size() != 0);
    for (int i = 0; i < N; i++) if (hc[i] > 0 || pv[i]) b = 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < N; i++) begin hc[i] = 0; pv[i] = 0; pl[i] = 0; end
    rr   = 0;
    movf = 0;
  endtask

  task automatic model_req(input int i, input bit lng);
    if (pv[i]) movf = 1;
    else begin pv[i] = 1; pl[i] = lng; end
  endtask

  // Drive one cycle, advance the model across the edge, return at edge+1
  task automatic tick(input logic [N-1:0] b, input logic r);
    int  w;
    bit  p;
    ev_t e;
    btn_in    = b;
    evt_ready = r;
    if (evt_valid && r) obs.push_back({evt_btn, evt_long});
    @(posedge clk);
    p = r && (mq.size() != 0);
    w = -1;
    if (mq.size() < D || p)
      for (int k = 0; k < N; k++) if (w < 0 && pv[(rr + k) % N]) w = (rr + k) % N;
    if (p) void'(mq.pop_front());
    if (w >= 0) begin
      e.btn = BW'(w);
      e.lng = pl[w];
      mq.push_back(e);
      pv[w] = 0;
      rr = (w + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (b[i]) begin
        hc[i]++;
        if (hc[i] == LC) model_req(i, 1'b1);
      end else begin
        if (hc[i] > 0 && hc[i] < LC) model_req(i, 1'b0);
        hc[i] = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    btn_in    = '0;
    evt_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic fill_five();
    for (int b = 0; b < N; b++) begin
      tick(N'(1) << b, 1'b0);
      tick('0, 1'b0);
    end
    tick(N'(1), 1'b0);
    tick('0, 1'b0);
    tick('0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({evt_valid, evt_btn, evt_long, overflow, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b required 00000",
               {evt_valid, evt_btn, evt_long, overflow, busy});
    end
  endtask

  task automatic test_short_press();
    obs.delete();
    for (int c = 0; c < 8; c++) begin
      tick((c < 3) ? N'(1) : '0, 1'b1);
      n_cmp++;
      if (dut_out() !== exp_out()) begin
        n_err++; $display("FAIL short_model c%0d: got %h required %h", c, dut_out(), exp_out());
      end
      n_cmp++;
      if (evt_valid !== (c == 4)) begin
        n_err++; $display("FAIL short_timing c%0d: valid %b required %b", c, evt_valid, c == 4);
      end
    end
    n_cmp++;
    if (obs.size() != 1 || obs[0] !== {2'd0, 1'b0}) begin
      n_err++; $display("FAIL short_events: got %0d events required 1 of {0,short}", obs.size());
    end
  endtask

  task automatic test_long_press();
    obs.delete();
    for (int c = 0; c < 30; c++) begin
      tick((c < 20) ? N'(4) : '0, 1'b1);
      n_cmp++;
      if (dut_out() !== exp_out()) begin
        n_err++; $display("FAIL long_model c%0d: got %h required %h", c, dut_out(), exp_out());
      end
      n_cmp++;
      if (evt_valid !== (c == 8)) begin
        n_err++; $display("FAIL long_timing c%0d: valid %b required %b", c, evt_valid, c == 8);
      end
    end
    n_cmp++;
    if (obs.size() != 1 || obs[0] !== {2'd2, 1'b1}) begin
      n_err++; $display("FAIL long_events: got %0d events required 1 of {2,long}", obs.size());
    end
  endtask

  task automatic test_round_robin();
    ev_t exp_seq[5];
    exp_seq = '{{2'd1, 1'b0}, {2'd2, 1'b0}, {2'd3, 1'b0}, {2'd0, 1'b0}, {2'd3, 1'b0}};
    do_reset();
    obs.delete();
    for (int c = 0; c < 16; c++) begin
      tick((c < 2) ? N'(4'b1110) : (c >= 6 && c < 8) ? N'(4'b1001) : '0, 1'b1);
      n_cmp++;
      if (dut_out() !== exp_out()) begin
        n_err++; $display("FAIL rr_model c%0d: got %h required %h", c, dut_out(), exp_out());
      end
    end
    n_cmp++;
    if (obs.size() != 5) begin
      n_err++; $display("FAIL rr_count: got %0d required 5", obs.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_cmp++;
        if (obs[k] !== exp_seq[k]) begin
          n_err++; $display("FAIL rr_order[%0d]: got %h required %h", k, obs[k], exp_seq[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    obs.delete();
    fill_five();
    for (int c = 0; c < 4; c++) begin
      tick('0, 1'b0);
      n_cmp++;
      if ({evt_valid, evt_btn, overflow, busy} !== {1'b1, 2'd0, 1'b0, 1'b1}) begin
        n_err++; $display("FAIL bp_hold c%0d: v/btn/ovf/busy %b required 10001", c,
                          {evt_valid, evt_btn, overflow, busy});
      end
    end
    for (int c = 0; c < 10; c++) begin
      tick('0, 1'b1);
      n_cmp++;
      if (dut_out() !== exp_out()) begin
        n_err++; $display("FAIL bp_drain c%0d: got %h required %h", c, dut_out(), exp_out());
      end
    end
    n_cmp++;
    if (obs.size() != 5 || obs[0].btn !== 2'd0 || obs[3].btn !== 2'd3 || obs[4].btn !== 2'd0
        || overflow !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL bp_result: events %0d ovf %b busy %b required 5/0/0",
                        obs.size(), overflow, busy);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    obs.delete();
    fill_five();
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL ovf_before: got %b required 0", overflow);
    end
    tick(N'(1), 1'b0);
    tick('0, 1'b0);
    tick('0, 1'b0);
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_set: got %b required 1", overflow);
    end
    for (int c = 0; c < 10; c++) begin
      tick('0, 1'b1);
      n_cmp++;
      if ({dut_out(), overflow} !== {exp_out(), movf}) begin
        n_err++; $display("FAIL ovf_drain c%0d: got %h required %h", c,
                          {dut_out(), overflow}, {exp_out(), movf});
      end
    end
    n_cmp++;
    if (obs.size() != 5 || overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_result: events %0d ovf %b required 5/1", obs.size(), overflow);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    obs.delete();
    tick(N'(1), 1'b0);
    tick('0, 1'b0);
    tick(N'(4), 1'b0);
    tick('0, 1'b0);
    tick('0, 1'b0);
    tick(N'(2), 1'b0);
    tick(N'(2), 1'b0);
    n_cmp++;
    if ({evt_valid, busy} !== 2'b11 || mq.size() != 2) begin
      n_err++; $display("FAIL mid_setup: valid/busy %b required 11", {evt_valid, busy});
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({evt_valid, busy, overflow} !== 3'b000) begin
      n_err++; $display("FAIL mid_async_clear: v/busy/ovf %b required 000",
                        {evt_valid, busy, overflow});
    end
    model_reset();
    btn_in = '0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 8; c++) begin
      tick('0, 1'b1);
      n_cmp++;
      if (evt_valid !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL mid_stale c%0d: valid %b busy %b required 0 0", c, evt_valid, busy);
      end
    end
    n_cmp++;
    if (obs.size() != 0) begin
      n_err++; $display("FAIL mid_events: got %0d required 0", obs.size());
    end
  endtask

  task automatic test_random();
    logic [N-1:0] b;
    logic         r;
    do_reset();
    b = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) b[i] = ~b[i];
      r = ((c % 300) < 90) ? 1'b0 : ($urandom_range(0, 3) != 0);
      tick(b, r);
      n_cmp++;
      if ({dut_out(), overflow, busy} !== {exp_out(), movf, exp_busy()}) begin
        n_err++; $display("FAIL random c%0d: out/ovf/busy %h required %h", c,
                          {dut_out(), overflow, busy}, {exp_out(), movf, exp_busy()});
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    btn_in    = '0;
    evt_ready = 1'b0;
    test_reset();
    test_short_press();
    test_long_press();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
